// File: rtl/amci_lite_master.sv
// AXI4-Lite master engine driven by the AMCI strobe/idle request interface.
// Define AMCI_TIMEOUT_EN to add a per-transaction watchdog of TIMEOUT_CYCLES clk cycles.
module amci_lite_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    output logic [2:0]  M_AXI_AWPROT,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic        M_AXI_WVALID,
    output logic [3:0]  M_AXI_WSTRB,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    output logic [2:0]  M_AXI_ARPROT,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic        M_AXI_RVALID,
    input  logic [1:0]  M_AXI_RRESP,
    output logic        M_AXI_RREADY,
    input  logic [31:0] AMCI_WADDR,
    input  logic [31:0] AMCI_WDATA,
    input  logic        AMCI_WRITE,
    output logic [1:0]  AMCI_WRESP,
    output logic        AMCI_WIDLE,
    input  logic [31:0] AMCI_RADDR,
    input  logic        AMCI_READ,
    output logic [31:0] AMCI_RDATA,
    output logic [1:0]  AMCI_RRESP,
    output logic        AMCI_RIDLE
);

    typedef enum logic [1:0] {W_IDLE, W_ADDR_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

    wstate_t     wstate_q, wstate_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic [1:0]  wresp_q, wresp_d;

    rstate_t     rstate_q, rstate_d;
    logic [31:0] araddr_q, araddr_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

`ifdef AMCI_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] wcnt_q, wcnt_d;
    logic [31:0] rcnt_q, rcnt_d;
`endif

    always_comb begin
        wstate_d  = wstate_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        wresp_d   = wresp_q;
`ifdef AMCI_TIMEOUT_EN
        wcnt_d    = wcnt_q;
`endif
        case (wstate_q)
            W_IDLE: begin
                if (AMCI_WRITE) begin
                    awaddr_d  = AMCI_WADDR;
                    wdata_d   = AMCI_WDATA;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    wstate_d  = W_ADDR_DATA;
`ifdef AMCI_TIMEOUT_EN
                    wcnt_d    = '0;
`endif
                end
            end
            W_ADDR_DATA: begin
                if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_AXI_WREADY) wvalid_d = 1'b0;
                // Both VALIDs already low means both handshakes finished last cycle.
                if (!awvalid_q && !wvalid_q) begin
                    bready_d = 1'b1;
                    wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                if (M_AXI_BVALID) begin
                    wresp_d  = M_AXI_BRESP;
                    bready_d = 1'b0;
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
`ifdef AMCI_TIMEOUT_EN
        if (wstate_q != W_IDLE && wstate_d != W_IDLE) begin
            if (wcnt_q == TMO_LAST) begin
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
                wresp_d   = 2'b10;
                wstate_d  = W_IDLE;
            end else begin
                wcnt_d = wcnt_q + 32'd1;
            end
        end
`endif
    end

    always_comb begin
        rstate_d  = rstate_q;
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
`ifdef AMCI_TIMEOUT_EN
        rcnt_d    = rcnt_q;
`endif
        case (rstate_q)
            R_IDLE: begin
                if (AMCI_READ) begin
                    araddr_d  = AMCI_RADDR;
                    arvalid_d = 1'b1;
                    rstate_d  = R_ADDR;
`ifdef AMCI_TIMEOUT_EN
                    rcnt_d    = '0;
`endif
                end
            end
            R_ADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    rstate_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (M_AXI_RVALID) begin
                    rdata_d  = M_AXI_RDATA;
                    rresp_d  = M_AXI_RRESP;
                    rready_d = 1'b0;
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
`ifdef AMCI_TIMEOUT_EN
        if (rstate_q != R_IDLE && rstate_d != R_IDLE) begin
            if (rcnt_q == TMO_LAST) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                rresp_d   = 2'b10;
                rdata_d   = 32'hDEAD_0000;
                rstate_d  = R_IDLE;
            end else begin
                rcnt_d = rcnt_q + 32'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wstate_q  <= W_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            wresp_q   <= 2'b00;
            rstate_q  <= R_IDLE;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
`ifdef AMCI_TIMEOUT_EN
            wcnt_q    <= '0;
            rcnt_q    <= '0;
`endif
        end else begin
            wstate_q  <= wstate_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            wresp_q   <= wresp_d;
            rstate_q  <= rstate_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
`ifdef AMCI_TIMEOUT_EN
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
`endif
        end
    end

    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_RREADY  = rready_q;

    // Idle is combinational so a requester sees busy in its own strobe cycle.
    assign AMCI_WIDLE = (wstate_q == W_IDLE) && !AMCI_WRITE;
    assign AMCI_RIDLE = (rstate_q == R_IDLE) && !AMCI_READ;
    assign AMCI_WRESP = wresp_q;
    assign AMCI_RDATA = rdata_q;
    assign AMCI_RRESP = rresp_q;

endmodule

// File: doc/amci_lite_master.md
Name: amci_lite_master

Overview:
- AXI4-Lite master engine: the initiator side for register-file slaves built on axi4_lite_slave.
- Local logic issues single-beat read/write requests via a strobe/idle "AMCI" interface; the block runs the AXI4-Lite handshakes and returns data and response.
- Independent write and read state machines; either may run concurrently with the other.
- Used by control sequencers and bring-up logic to program blocks such as the traffic generator over the AXI interconnect.

Parameters:
- TIMEOUT_CYCLES, 1024: watchdog limit in clk cycles per transaction. Used only when AMCI_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- M_AXI_AWADDR  out  32  write address
- M_AXI_AWVALID  out  1  write address valid
- M_AXI_AWPROT  out  3  constant 3'b000
- M_AXI_AWREADY  in  1  write address ready
- M_AXI_WDATA  out  32  write data
- M_AXI_WVALID  out  1  write data valid
- M_AXI_WSTRB  out  4  constant 4'hF
- M_AXI_WREADY  in  1  write data ready
- M_AXI_BRESP  in  2  write response
- M_AXI_BVALID  in  1  write response valid
- M_AXI_BREADY  out  1  write response ready
- M_AXI_ARADDR  out  32  read address
- M_AXI_ARVALID  out  1  read address valid
- M_AXI_ARPROT  out  3  constant 3'b000
- M_AXI_ARREADY  in  1  read address ready
- M_AXI_RDATA  in  32  read data
- M_AXI_RVALID  in  1  read data valid
- M_AXI_RRESP  in  2  read response
- M_AXI_RREADY  out  1  read data ready
- AMCI_WADDR  in  32  write request address
- AMCI_WDATA  in  32  write request data
- AMCI_WRITE  in  1  one-cycle write start strobe
- AMCI_WRESP  out  2  captured BRESP of the last write
- AMCI_WIDLE  out  1  write engine idle
- AMCI_RADDR  in  32  read request address
- AMCI_READ  in  1  one-cycle read start strobe
- AMCI_RDATA  out  32  captured RDATA of the last read
- AMCI_RRESP  out  2  captured RRESP of the last read
- AMCI_RIDLE  out  1  read engine idle

Behaviour:
- Reset: all VALID/READY outputs 0; AMCI_WRESP, AMCI_RRESP, AMCI_RDATA = 0; both FSMs go to IDLE.
- Reset mid-transaction aborts the transaction at the next clk edge. No completion is reported.
- Write FSM states: W_IDLE, W_ADDR_DATA, W_RESP.
  - W_IDLE: when AMCI_WRITE=1, latch AMCI_WADDR/AMCI_WDATA to AWADDR/WDATA. Next cycle AWVALID=WVALID=1. Go to W_ADDR_DATA.
  - W_ADDR_DATA: AWVALID drops the cycle after AWVALID&&AWREADY. WVALID drops the cycle after WVALID&&WREADY. The two handshakes are independent and may occur in either order or the same cycle.
  - When both handshakes are complete, assert BREADY and go to W_RESP. Minimum one cycle between the last handshake and BREADY.
  - W_RESP: on BVALID&&BREADY, capture BRESP into AMCI_WRESP, drop BREADY, go to W_IDLE.
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: when AMCI_READ=1, latch the address; ARVALID=1 next cycle.
  - R_ADDR: after ARVALID&&ARREADY, drop ARVALID, set RREADY=1, go to R_DATA.
  - R_DATA: on RVALID&&RREADY, capture RDATA/RRESP, drop RREADY, go to R_IDLE.
- Idle outputs:
  - AMCI_WIDLE = (write state==W_IDLE) && !AMCI_WRITE.
  - AMCI_RIDLE = (read state==R_IDLE) && !AMCI_READ.
  - Both are combinational, so the requester sees busy in the strobe cycle.
- Completion is signalled by the idle output returning to 1. AMCI_WRESP/AMCI_RRESP/AMCI_RDATA are valid from that cycle and hold until the next completion.
- A strobe while the matching engine is busy is ignored: no queuing, no error.
- Simultaneous AMCI_WRITE and AMCI_READ: both engines start; the channels are independent.
- VALID never deasserts before its handshake, except on reset (and on timeout, below).
- Minimum write latency, strobe to AMCI_WIDLE=1 with all READYs high: 4 cycles.
- Minimum read latency, strobe to AMCI_RIDLE=1 with all READYs high: 3 cycles.

Optional Feature:
- Macro AMCI_TIMEOUT_EN.
- Defined:
  - Each engine has a cycle counter, cleared when it leaves IDLE and incremented every busy cycle.
  - When the count reaches TIMEOUT_CYCLES, the engine drops all its VALID/READY outputs and returns to IDLE.
  - The engine reports 2'b10 (SLVERR); a timed-out read also sets AMCI_RDATA = 32'hDEAD_0000.
  - This is a fault-recovery-only deviation from AXI VALID-hold rules.
- Undefined: no counters; engines wait indefinitely.

Test Plan:
- Write, all READYs tied 1: AMCI_WADDR=0x10, AMCI_WDATA=0x1 -> AWADDR=0x10, WDATA=0x1, WSTRB=0xF; AMCI_WRESP=0; AMCI_WIDLE high 4 cycles after the strobe.
- Write, WREADY asserted 3 cycles before AWREADY; slave returns BRESP=2'b11 -> WVALID drops first, BREADY only after both handshakes, AMCI_WRESP=3.
- Read 0x0C, ARREADY delayed 5 cycles, RDATA=0xDEADBEEF, RRESP=0 -> ARVALID held 5 cycles, AMCI_RDATA=0xDEADBEEF, AMCI_RRESP=0.
- Concurrent AMCI_WRITE and AMCI_READ in the same cycle, plus a second AMCI_WRITE while busy -> both complete correctly; the second write produces no AWVALID.
- resetn=0 for 1 cycle while in W_RESP -> next cycle all VALID/READY=0, AMCI_WIDLE=1, AMCI_WRESP=0.
- With AMCI_TIMEOUT_EN and TIMEOUT_CYCLES=16, ARREADY held 0 -> ARVALID drops after 16 busy cycles, AMCI_RRESP=2, AMCI_RDATA=0xDEAD0000.
